// File: rtl/qupls_cpv_write_sequencer_pkg.sv
// Shared types for the checkpoint valid-bit write sequencer.
// Lane/port widths and the queued update entry live here.
package qupls_cpv_write_sequencer_pkg;

   localparam int NCHECK = 32;
   localparam int PREGS  = 512;

   localparam int CPV_NIN   = 8;
   localparam int CPV_NOUT  = 4;
   localparam int CPV_DEPTH = 16;

   typedef logic [$clog2(NCHECK)-1:0] checkpt_ndx_t;
   typedef logic [$clog2(PREGS)-1:0]  pregno_t;

   typedef struct packed {
      checkpt_ndx_t cp;
      pregno_t      preg;
      logic         val;
   } cpv_upd_t;

   typedef enum logic [1:0] {
      CPV_IDLE,
      CPV_DRAIN,
      CPV_COPY
   } cpv_state_t;

endpackage

// File: rtl/qupls_cpv_write_sequencer_if.sv
// Lane, copy-request and RAM write-port bundle of the
// checkpoint valid-bit write sequencer.
interface qupls_cpv_write_sequencer_if
   import qupls_cpv_write_sequencer_pkg::*;
#(
   parameter int NIN   = CPV_NIN,
   parameter int NOUT  = CPV_NOUT,
   parameter int DEPTH = CPV_DEPTH
);

   logic [NIN-1:0]          in_v;
   checkpt_ndx_t [NIN-1:0]  in_cp;
   pregno_t [NIN-1:0]       in_preg;
   logic [NIN-1:0]          in_val;
   logic                    in_rdy;

   logic                    ncp_req;
   checkpt_ndx_t            ncp_req_ra;
   checkpt_ndx_t            ncp_req_wa;
   logic                    ncp_ack;

   logic                    ena;
   logic [NOUT-1:0]         wea;
   checkpt_ndx_t [NOUT-1:0] cpa;
   pregno_t [NOUT-1:0]      prega;
   logic [NOUT-1:0]         dina;

   logic                    ncp;
   checkpt_ndx_t            ncp_ra;
   checkpt_ndx_t            ncp_wa;
   logic [$clog2(DEPTH):0]  q_cnt;

   modport master (
      output in_v, in_cp, in_preg, in_val,
      output ncp_req, ncp_req_ra, ncp_req_wa,
      input  in_rdy, ncp_ack,
      input  ena, wea, cpa, prega, dina,
      input  ncp, ncp_ra, ncp_wa, q_cnt
   );

   modport slave (
      input  in_v, in_cp, in_preg, in_val,
      input  ncp_req, ncp_req_ra, ncp_req_wa,
      output in_rdy, ncp_ack,
      output ena, wea, cpa, prega, dina,
      output ncp, ncp_ra, ncp_wa, q_cnt
   );

endinterface

// File: rtl/qupls_cpv_lane_compact.sv
// Packs valid update lanes (reg 0 dropped) into ascending
// slots using a prefix count and a per-slot select.
module qupls_cpv_lane_compact
   import qupls_cpv_write_sequencer_pkg::*;
#(
   parameter int NIN = CPV_NIN
)(
   input  logic [NIN-1:0]         v,
   input  checkpt_ndx_t [NIN-1:0] cp,
   input  pregno_t [NIN-1:0]      preg,
   input  logic [NIN-1:0]         val,
   output cpv_upd_t [NIN-1:0]     ent,
   output logic [$clog2(NIN):0]   cnt
);

   localparam int NW = $clog2(NIN) + 1;

   logic [NIN-1:0] keep;
   logic [NW-1:0]  pos [NIN];
   logic [NW-1:0]  acc;

   always_comb begin
      keep = v;
      for (int i = 0; i < NIN; i++)
         if (preg[i] == '0)
            keep[i] = 1'b0;
   end

   always_comb begin
      acc = '0;
      for (int i = 0; i < NIN; i++) begin
         pos[i] = acc;
         acc    = acc + NW'(keep[i]);
      end
      cnt = acc;
   end

   // slot j can only be fed by lanes j and above
   always_comb begin
      for (int j = 0; j < NIN; j++) begin
         ent[j] = '0;
         for (int i = j; i < NIN; i++)
            if (keep[i] && pos[i] == NW'(j))
               ent[j] = {cp[i], preg[i], val[i]};
      end
   end

endmodule

// File: rtl/qupls_cpv_write_sequencer.sv
// Queues valid-bit updates, drains them to the CPV RAM and orders
// checkpoint copies behind them. Option: QUPLS_CPV_BYPASS_EN.
module qupls_cpv_write_sequencer
   import qupls_cpv_write_sequencer_pkg::*;
#(
   parameter int NIN   = CPV_NIN,
   parameter int NOUT  = CPV_NOUT,
   parameter int DEPTH = CPV_DEPTH
)(
   input logic                        clk,
   input logic                        rst,
   qupls_cpv_write_sequencer_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int NW = $clog2(NIN) + 1;

   cpv_state_t         state;
   cpv_state_t         state_n;
   cpv_upd_t           mem [DEPTH];
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      ndrain;
   logic               started;
   logic               rdy;
   logic               enq;
   logic               byp;
   checkpt_ndx_t       ra_q;
   checkpt_ndx_t       wa_q;
   cpv_upd_t [NIN-1:0] cent;
   logic [NW-1:0]      ccnt;
   logic [NOUT-1:0]    we;

   qupls_cpv_lane_compact #(
      .NIN (NIN)
   ) u_compact (
      .v    (bus.in_v),
      .cp   (bus.in_cp),
      .preg (bus.in_preg),
      .val  (bus.in_val),
      .ent  (cent),
      .cnt  (ccnt)
   );

   // free space ignores this cycle's drain
   always_comb begin
      rdy = started && state == CPV_IDLE &&
            (CW'(DEPTH) - cnt) >= CW'(NIN);
`ifdef QUPLS_CPV_BYPASS_EN
      byp = rdy && cnt == '0 && ccnt <= NW'(NOUT);
`else
      byp = 1'b0;
`endif
      enq = rdy && !byp && ccnt != '0;
      ndrain = '0;
      if (state != CPV_COPY)
         ndrain = (cnt > CW'(NOUT)) ? CW'(NOUT) : cnt;
   end

   always_comb begin
      we        = '0;
      bus.cpa   = '0;
      bus.prega = '0;
      bus.dina  = '0;
      for (int p = 0; p < NOUT; p++) begin
         if (byp) begin
            if (NW'(p) < ccnt) begin
               we[p]        = 1'b1;
               bus.cpa[p]   = cent[p].cp;
               bus.prega[p] = cent[p].preg;
               bus.dina[p]  = cent[p].val;
            end
         end else if (CW'(p) < ndrain) begin
            we[p]        = 1'b1;
            bus.cpa[p]   = mem[rd_ptr + PW'(p)].cp;
            bus.prega[p] = mem[rd_ptr + PW'(p)].preg;
            bus.dina[p]  = mem[rd_ptr + PW'(p)].val;
         end
      end
      bus.wea = we;
      bus.ena = |we;
   end

   assign bus.in_rdy  = rdy;
   assign bus.q_cnt   = cnt;
   assign bus.ncp     = state == CPV_COPY;
   assign bus.ncp_ack = state == CPV_COPY;
   assign bus.ncp_ra  = (state == CPV_COPY) ? ra_q : '0;
   assign bus.ncp_wa  = (state == CPV_COPY) ? wa_q : '0;

   always_comb begin
      state_n = state;
      unique case (state)
         CPV_IDLE:
            if (bus.ncp_req)
               state_n = (cnt == '0 && !enq) ?
                         CPV_COPY : CPV_DRAIN;
         CPV_DRAIN:
            if (cnt == '0)
               state_n = CPV_COPY;
         CPV_COPY:
            state_n = CPV_IDLE;
         default:
            state_n = CPV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= CPV_IDLE;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         cnt     <= '0;
         started <= 1'b0;
         ra_q    <= '0;
         wa_q    <= '0;
      end else begin
         started <= 1'b1;
         state   <= state_n;
         rd_ptr  <= rd_ptr + PW'(ndrain);
         if (enq)
            wr_ptr <= wr_ptr + PW'(ccnt);
         cnt <= cnt - ndrain + (enq ? CW'(ccnt) : '0);
         if (state == CPV_IDLE && bus.ncp_req) begin
            ra_q <= bus.ncp_req_ra;
            wa_q <= bus.ncp_req_wa;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq)
         for (int i = 0; i < NIN; i++)
            if (NW'(i) < ccnt)
               mem[wr_ptr + PW'(i)] <= cent[i];
   end

endmodule
